blackparrot_fpga_host_csr_sequencer: RTL
========================================

// Module: blackparrot_fpga_host_csr_sequencer
// PURPOSE
//  AXI-Lite master that drives the FPGA-host CSR port from fabric logic instead of host software.
//  It shares that single port between two requesters: the BP MMIO drain and the MMIO response writer.
//  - MMIO drain: polls count CSR 'h8, then reads data CSR 'hC once per reported word.
//  - Response writer: writes response words to CSR 'h4.
//  Drained words leave on a ready/valid stream; response words enter on a ready/valid stream.
// PARAMETERS
//  M_AXIL_ADDR_WIDTH  64   AXI-Lite address width
//  M_AXIL_DATA_WIDTH  32   AXI-Lite data width; must be 32
//  POLL_INTERVAL_P    64   idle cycles after a poll returning 0 before next poll; >=1
//  CNT_ADDR_P         'h8  MMIO out-buffer count CSR
//  DATA_ADDR_P        'hC  MMIO out-buffer data CSR
//  RESP_ADDR_P        'h4  MMIO in-buffer CSR
// PORTS
//  m_axil_aclk      in   1   clock; all logic on rising edge
//  m_axil_aresetn   in   1   asynchronous active-low reset
//  enable_i         in   1   1 = sequencer may start new transactions
//  m_axil_aw*       out/in   awaddr[A], awvalid, awready(in), awprot[3] (=3'b000)
//  m_axil_w*        out/in   wdata[32], wvalid, wready(in), wstrb[4] (=4'hF)
//  m_axil_b*        in/out   bvalid(in), bready, bresp[2](in)
//  m_axil_ar*       out/in   araddr[A], arvalid, arready(in), arprot[3] (=3'b000)
//  m_axil_r*        in/out   rdata[32](in), rvalid(in), rready, rresp[2](in)
//  rx_data_o        out  32  drained MMIO word
//  rx_v_o           out  1   rx_data_o valid
//  rx_ready_and_i   in   1   consumer accepts rx word
//  tx_data_i        in   32  response word to write to RESP_ADDR_P
//  tx_v_i           in   1   tx word valid
//  tx_ready_and_o   out  1   tx word accepted (pulses 1 cycle when captured)
//  error_o          out  1   sticky: any bresp/rresp != OKAY since reset
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; addresses/data 0; remaining=0; poll_timer=0 (poll due); last_grant=RD; error_o=0.
//  Exactly one AXI-Lite transaction outstanding at any time; no ID/ordering logic.
//  States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RX_HOLD.
//  Read work pending when all hold:
//  - enable_i=1
//  - rx buffer empty
//  - remaining!=0, or (remaining==0 and poll_timer==0)
//  Write work pending when tx_v_i=1 and enable_i=1.
//  IDLE arbitration:
//  - Only one pending: grant it.
//  - Both pending: round-robin, grant the side opposite last_grant.
//  - Update last_grant on each grant.
//  Write grant:
//  - Capture tx_data_i; tx_ready_and_o=1 that cycle; go WR_ADDR_DATA.
//  - awvalid and wvalid rise together; each drops on its own handshake (aw_done/w_done flags).
//  - When both done: bready=1 (WR_RESP); on bvalid return IDLE; bresp!=0 sets error_o.
//  Read grant:
//  - araddr = CNT_ADDR_P if remaining==0, else DATA_ADDR_P.
//  - arvalid held until arready; then rready=1 in RD_DATA until rvalid.
//  - Poll response: remaining<=rdata; if rdata==0 then poll_timer<=POLL_INTERVAL_P.
//  - Data response: rx_data_o<=rdata, rx_v_o<=1, remaining--.
//  - rresp!=0 sets error_o. A poll then treats count as 0; a data read drops the word and still decrements remaining.
//  - Return IDLE.
//  rx buffer: single entry; rx_v_o stays 1 until rx_ready_and_i; data stable while valid.
//  - Data reads are never issued while rx_v_o=1, so back-pressure stalls only the drain side.
//  poll_timer decrements each cycle while nonzero, independent of state.
//  enable_i falling mid-transaction: current transaction completes; no new grant.
//  Latency: fastest word = grant + AR handshake + R handshake; rx_v_o rises the cycle after rvalid&rready.
//  - Minimum 3 cycles from IDLE with arready=rvalid=1.
//  Async reset mid-transaction abandons it; the CSR slave is reset in the same domain.
// TESTING
//  Reset: all outputs 0; first action with enable_i=1 and tx_v_i=0 is AR to 'h8.
//  Poll returns 3, data rdata=A,B,C, rx_ready_and_i=1 -> rx emits A,B,C in order; 4 ARs total ('h8,'hC,'hC,'hC).
//  Poll returns 0 -> no AR for 64 cycles; next AR at 'h8 after timer expiry.
//  tx_v_i=1 constantly during 4-word drain -> AR and write transactions alternate; every write to 'h4 carries its word.
//  awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds; single B accepted.
//  rx_ready_and_i=0 with remaining=2 -> one word held stable, no further 'hC AR until consumed.
//  rresp=SLVERR on poll -> error_o=1 sticky, remaining=0; bench restores OKAY and draining resumes.

Source files
------------

// File: rtl/blackparrot_fpga_host_csr_sequencer_if.sv
// AXI-Lite bundle between the CSR sequencer (master) and the FPGA-host CSR port (slave).
interface blackparrot_fpga_host_csr_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [2:0]              awprot;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [2:0]              arprot;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;
    logic [1:0]              rresp;

    modport master (
        output awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );

    modport slave (
        input  awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/blackparrot_fpga_host_csr_sequencer.sv
// Fabric-side AXI-Lite master sharing the FPGA-host CSR port between the MMIO
// drain (count poll + data reads) and the MMIO response writer.
module blackparrot_fpga_host_csr_sequencer #(
    parameter int unsigned M_AXIL_ADDR_WIDTH = 64,
    parameter int unsigned M_AXIL_DATA_WIDTH = 32,
    parameter int unsigned POLL_INTERVAL_P   = 64,
    parameter logic [63:0] CNT_ADDR_P        = 64'h8,
    parameter logic [63:0] DATA_ADDR_P       = 64'hC,
    parameter logic [63:0] RESP_ADDR_P       = 64'h4
) (
    input  logic                         m_axil_aclk,
    input  logic                         m_axil_aresetn,
    input  logic                         enable_i,
    blackparrot_fpga_host_csr_sequencer_if.master m_axil,
    output logic [M_AXIL_DATA_WIDTH-1:0] rx_data_o,
    output logic                         rx_v_o,
    input  logic                         rx_ready_and_i,
    input  logic [M_AXIL_DATA_WIDTH-1:0] tx_data_i,
    input  logic                         tx_v_i,
    output logic                         tx_ready_and_o,
    output logic                         error_o
);
    localparam int unsigned AW      = M_AXIL_ADDR_WIDTH;
    localparam int unsigned DW      = M_AXIL_DATA_WIDTH;
    localparam int unsigned TIMER_W = $clog2(POLL_INTERVAL_P + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RX_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                 bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                 rd_poll_q, rd_poll_d, last_wr_q, last_wr_d;
    logic [DW-1:0]        remaining_q, remaining_d;
    logic [TIMER_W-1:0]   poll_timer_q, poll_timer_d;
    logic [DW-1:0]        rx_data_q, rx_data_d;
    logic                 rx_v_q, rx_v_d, error_q, error_d;

    logic read_pend, write_pend, grant_wr, grant_rd;
    logic aw_hs, w_hs, rd_err;

    // Round-robin between drain and response writer; last_wr_q tracks the previous grant.
    assign read_pend  = enable_i && !rx_v_q &&
                        ((remaining_q != '0) || (poll_timer_q == '0));
    assign write_pend = enable_i && tx_v_i;
    assign grant_wr   = (state_q == IDLE) && write_pend && (!read_pend || !last_wr_q);
    assign grant_rd   = (state_q == IDLE) && read_pend && !grant_wr;
    assign aw_hs      = awvalid_q && m_axil.awready;
    assign w_hs       = wvalid_q && m_axil.wready;
    assign rd_err     = (m_axil.rresp != 2'b00);

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rd_poll_d    = rd_poll_q;
        last_wr_d    = last_wr_q;
        remaining_d  = remaining_q;
        poll_timer_d = (poll_timer_q != '0) ? poll_timer_q - TIMER_W'(1) : poll_timer_q;
        rx_data_d    = rx_data_q;
        rx_v_d       = (rx_v_q && rx_ready_and_i) ? 1'b0 : rx_v_q;
        error_d      = error_q;

        unique case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR_ADDR_DATA;
                    awaddr_d  = AW'(RESP_ADDR_P);
                    wdata_d   = tx_data_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = RD_ADDR;
                    arvalid_d = 1'b1;
                    rd_poll_d = (remaining_q == '0);
                    araddr_d  = (remaining_q == '0) ? AW'(CNT_ADDR_P) : AW'(DATA_ADDR_P);
                    last_wr_d = 1'b0;
                end
            end
            WR_ADDR_DATA: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid) begin
                    bready_d = 1'b0;
                    state_d  = IDLE;
                    if (m_axil.bresp != 2'b00) error_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                    if (rd_err) error_d = 1'b1;
                    // A failed poll behaves like an empty buffer; a failed data read drops the word.
                    if (rd_poll_q) begin
                        if (rd_err || (m_axil.rdata == '0)) begin
                            remaining_d  = '0;
                            poll_timer_d = TIMER_W'(POLL_INTERVAL_P);
                        end else begin
                            remaining_d = m_axil.rdata;
                        end
                    end else begin
                        remaining_d = remaining_q - DW'(1);
                        if (!rd_err) begin
                            rx_data_d = m_axil.rdata;
                            rx_v_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
        if (!m_axil_aresetn) begin
            state_q      <= IDLE;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rd_poll_q    <= 1'b0;
            last_wr_q    <= 1'b0;
            remaining_q  <= '0;
            poll_timer_q <= '0;
            rx_data_q    <= '0;
            rx_v_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rd_poll_q    <= rd_poll_d;
            last_wr_q    <= last_wr_d;
            remaining_q  <= remaining_d;
            poll_timer_q <= poll_timer_d;
            rx_data_q    <= rx_data_d;
            rx_v_q       <= rx_v_d;
            error_q      <= error_d;
        end
    end

    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.rready  = rready_q;

    // Ready pulses in the capture cycle so the tx source sees a true handshake.
    assign tx_ready_and_o = grant_wr;
    assign rx_data_o      = rx_data_q;
    assign rx_v_o         = rx_v_q;
    assign error_o        = error_q;
endmodule
